grad_desc_update_ctrl: RTL

Iteration controller and parameter register file for the gradient-descent datapath. It holds the current parameters a, b, c, d (Q8.8) and launches one gradient/value evaluation per iteration on the upstream gradient stage. It consumes that stage's per-parameter step values and applies a saturating update p <= p - diff. It stops on convergence, on the iteration limit, or on an upstream overflow.

---
 rtl/grad_desc_update_ctrl.sv | 282 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/grad_desc_update_ctrl.sv
// grad_desc_update_ctrl
// Iteration controller and parameter register file for the gradient-descent
// datapath. It holds the Q8.8 parameters a..d, launches one evaluation per
// iteration on the upstream gradient stage, and applies the returned steps
// with a saturating update p <= sat16(p - diff). A run ends on convergence,
// on the MAX_ITER update limit, or on an upstream overflow.
//
// Optional feature macro: GD_BEST_TRACK_EN
//   defined   : value_out tracks the minimum value seen in the run, and the
//               parameter set that produced it is restored at the end of run.
//   undefined : value_out is the last captured value; params keep their
//               last updated value.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   start                 begin a run (only honoured in IDLE)
//   func_start            one-cycle launch pulse to the gradient stage
//   func_done             one-cycle result-valid pulse from the gradient stage
//   value_in              signed Q24.8 function value
//   a..d_diff_in          signed Q8.8 step values
//   ovf_in                upstream overflow, valid with func_done
//   a..d_out              current Q8.8 params (drive the gradient stage)
//   value_out             last (or best) captured value
//   iter_count            completed updates in the current/last run
//   busy                  high outside IDLE
//   done                  one-cycle end-of-run pulse
//   converged, overflow   sticky run-status flags, cleared on start
module grad_desc_update_ctrl #(
  parameter logic [15:0] MAX_ITER    = 16'd1000,
  parameter logic [15:0] CONV_THRESH = 16'h0001,
  parameter logic [15:0] A_INIT      = 16'h0000,
  parameter logic [15:0] B_INIT      = 16'h0000,
  parameter logic [15:0] C_INIT      = 16'h0000,
  parameter logic [15:0] D_INIT      = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        func_start,
  input  logic        func_done,
  input  logic [31:0] value_in,
  input  logic [15:0] a_diff_in,
  input  logic [15:0] b_diff_in,
  input  logic [15:0] c_diff_in,
  input  logic [15:0] d_diff_in,
  input  logic        ovf_in,
  output logic [15:0] a_out,
  output logic [15:0] b_out,
  output logic [15:0] c_out,
  output logic [15:0] d_out,
  output logic [31:0] value_out,
  output logic [15:0] iter_count,
  output logic        busy,
  output logic        done,
  output logic        converged,
  output logic        overflow
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_UPDATE,
    S_FINISH
  } state_t;

  // Lane i of this vector is the start value of parameter i (a=0 .. d=3).
  localparam logic [63:0] INIT_VEC = {D_INIT, C_INIT, B_INIT, A_INIT};

`ifdef GD_BEST_TRACK_EN
  localparam logic [31:0] VALUE_RST = 32'h7FFF_FFFF;
`else
  localparam logic [31:0] VALUE_RST = 32'h0000_0000;
`endif

  state_t      state_q, state_d;
  logic [15:0] p_q    [4];
  logic [15:0] p_d    [4];
  logic [15:0] diff_q [4];
  logic [15:0] diff_d [4];
  logic [15:0] diff_in[4];
  logic [15:0] p_sub  [4];
  logic [3:0]  lane_conv;
  logic [31:0] value_q, value_d;
  logic        ovf_cap_q, ovf_cap_d;
  logic [15:0] iter_q, iter_d;
  logic        conv_q, conv_d;
  logic        ovf_q, ovf_d;
  logic        func_start_q, func_start_d;
  logic        done_q, done_d;
  logic [15:0] iter_inc;

`ifdef GD_BEST_TRACK_EN
  logic [15:0] best_q [4];
  logic [15:0] best_d [4];
  logic [31:0] cap_value_q, cap_value_d;
`endif

  assign diff_in[0] = a_diff_in;
  assign diff_in[1] = b_diff_in;
  assign diff_in[2] = c_diff_in;
  assign diff_in[3] = d_diff_in;

  assign iter_inc = iter_q + 16'd1;

  // Per-parameter arithmetic: 17-bit signed subtract with clamp, and 17-bit
  // magnitude so that |0x8000| = 32768 can never pass the threshold.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [16:0] diff_ext;
      logic [16:0] delta;
      logic [16:0] mag;

      assign diff_ext = {diff_q[gi][15], diff_q[gi]};
      assign delta    = {p_q[gi][15], p_q[gi]} - diff_ext;
      // Top two bits disagree only when the result left the 16-bit range.
      assign p_sub[gi] = (delta[16] != delta[15])
                         ? (delta[16] ? 16'h8000 : 16'h7FFF)
                         : delta[15:0];
      assign mag = diff_ext[16] ? (17'd0 - diff_ext) : diff_ext;
      assign lane_conv[gi] = (mag <= {1'b0, CONV_THRESH});
    end
  endgenerate

  always_comb begin
    state_d      = state_q;
    value_d      = value_q;
    ovf_cap_d    = ovf_cap_q;
    iter_d       = iter_q;
    conv_d       = conv_q;
    ovf_d        = ovf_q;
    func_start_d = 1'b0;
    done_d       = 1'b0;
    for (int i = 0; i < 4; i++) begin
      p_d[i]    = p_q[i];
      diff_d[i] = diff_q[i];
    end
`ifdef GD_BEST_TRACK_EN
    cap_value_d = cap_value_q;
    for (int i = 0; i < 4; i++) begin
      best_d[i] = best_q[i];
    end
`endif

    case (state_q)
      S_IDLE: begin
        // start takes priority; a func_done arriving here is simply dropped.
        if (start) begin
          for (int i = 0; i < 4; i++) begin
            p_d[i] = INIT_VEC[i*16 +: 16];
          end
          iter_d  = 16'd0;
          conv_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = S_LAUNCH;
`ifdef GD_BEST_TRACK_EN
          value_d = VALUE_RST;
          for (int i = 0; i < 4; i++) begin
            best_d[i] = INIT_VEC[i*16 +: 16];
          end
`endif
        end
      end

      S_LAUNCH: begin
        // The launch pulse is registered, so it appears during the cycle
        // after LAUNCH, aligned with the first WAIT cycle.
        func_start_d = 1'b1;
        state_d      = S_WAIT;
      end

      S_WAIT: begin
        if (func_done) begin
          for (int i = 0; i < 4; i++) begin
            diff_d[i] = diff_in[i];
          end
          ovf_cap_d = ovf_in;
`ifdef GD_BEST_TRACK_EN
          cap_value_d = value_in;
`else
          value_d = value_in;
`endif
          state_d = S_UPDATE;
        end
      end

      S_UPDATE: begin
`ifdef GD_BEST_TRACK_EN
        // Remember the params that produced the lowest value so far; p_q
        // here is still the set the gradient stage evaluated.
        if ($signed(cap_value_q) < $signed(value_q)) begin
          value_d = cap_value_q;
          for (int i = 0; i < 4; i++) begin
            best_d[i] = p_q[i];
          end
        end
`endif
        if (ovf_cap_q) begin
          ovf_d   = 1'b1;
          state_d = S_FINISH;
        end else if (&lane_conv) begin
          conv_d  = 1'b1;
          state_d = S_FINISH;
        end else begin
          for (int i = 0; i < 4; i++) begin
            p_d[i] = p_sub[i];
          end
          iter_d  = iter_inc;
          state_d = (iter_inc == MAX_ITER) ? S_FINISH : S_LAUNCH;
        end
      end

      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
`ifdef GD_BEST_TRACK_EN
        for (int i = 0; i < 4; i++) begin
          p_d[i] = best_d[i];
        end
`endif
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      value_q      <= VALUE_RST;
      ovf_cap_q    <= 1'b0;
      iter_q       <= 16'd0;
      conv_q       <= 1'b0;
      ovf_q        <= 1'b0;
      func_start_q <= 1'b0;
      done_q       <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        p_q[i]    <= INIT_VEC[i*16 +: 16];
        diff_q[i] <= 16'd0;
      end
`ifdef GD_BEST_TRACK_EN
      cap_value_q <= 32'd0;
      for (int i = 0; i < 4; i++) begin
        best_q[i] <= INIT_VEC[i*16 +: 16];
      end
`endif
    end else begin
      state_q      <= state_d;
      value_q      <= value_d;
      ovf_cap_q    <= ovf_cap_d;
      iter_q       <= iter_d;
      conv_q       <= conv_d;
      ovf_q        <= ovf_d;
      func_start_q <= func_start_d;
      done_q       <= done_d;
      for (int i = 0; i < 4; i++) begin
        p_q[i]    <= p_d[i];
        diff_q[i] <= diff_d[i];
      end
`ifdef GD_BEST_TRACK_EN
      cap_value_q <= cap_value_d;
      for (int i = 0; i < 4; i++) begin
        best_q[i] <= best_d[i];
      end
`endif
    end
  end

  assign func_start = func_start_q;
  assign done       = done_q;
  assign busy       = (state_q != S_IDLE);
  assign converged  = conv_q;
  assign overflow   = ovf_q;
  assign iter_count = iter_q;
  assign value_out  = value_q;
  assign a_out      = p_q[0];
  assign b_out      = p_q[1];
  assign c_out      = p_q[2];
  assign d_out      = p_q[3];

endmodule
